// File: rtl/clk_buffer_pkg.sv
// Shared definitions for the clk_buffer clock-distribution slice.
//   CNT_W_DEFAULT : default width of the mclk rising-edge counter
//   cnt_t         : counter type at the default width
package clk_buffer_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

endpackage

// File: rtl/clk_buffer_gate.sv
// clk_gate_cell: glitch-free clock gate (enable latch + AND).
// Kept isolated so it can be replaced by a library ICG cell.
// Compiled only when CLK_BUFFER_GATE_EN is defined.
// Ports:
//   clk_in  : clock to be gated
//   en      : 1 = pass clock; sampled while clk_in is low
//   rst_n   : async active-low; forces the enable latch open (clock runs)
//   clk_out : clk_in & latched enable
`ifdef CLK_BUFFER_GATE_EN
module clk_gate_cell (
  input  logic clk_in,
  input  logic en,
  input  logic rst_n,
  output logic clk_out
);

  logic r_en_lat;

  // Transparent only while clk_in is low, so en cannot change during a
  // high phase and clk_out pulses are either whole or absent.
  always_latch begin
    if (!rst_n) begin
      r_en_lat <= 1'b1;
    end else if (!clk_in) begin
      r_en_lat <= en;
    end
  end

  assign clk_out = clk_in & r_en_lat;

endmodule
`endif

// File: rtl/clk_buffer.sv
// clk_buffer: zero-skew clock buffer (bclk re-drives mclk, same phase and
// frequency) with a small mclk-domain status block for clock-tree bring-up.
// Optional feature macro: CLK_BUFFER_GATE_EN (adds gate_en and a
// glitch-free clock gate in the bclk path).
// Ports:
//   mclk    : master clock, the only clock
//   bclk    : buffered clock (mclk, or gated mclk with CLK_BUFFER_GATE_EN)
//   rst_n   : async active-low reset for the status logic only
//   cyc_cnt : mclk rising edges since reset release, modulo 2^CNT_W
//   alive   : 1 once an mclk rising edge has occurred after reset release
//   gate_en : (CLK_BUFFER_GATE_EN only) 1 = pass the clock through
module clk_buffer
  import clk_buffer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             mclk,
  output logic             bclk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic             alive
`ifdef CLK_BUFFER_GATE_EN
  ,
  input  logic             gate_en
`endif
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_alive;

  // Clock path is purely combinational and independent of the status logic.
`ifdef CLK_BUFFER_GATE_EN
  clk_gate_cell u_gate (
    .clk_in  (mclk),
    .en      (gate_en),
    .rst_n   (rst_n),
    .clk_out (bclk)
  );
`else
  assign bclk = mclk;
`endif

  // Status runs on ungated mclk; counter wraps silently.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_alive <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
      r_alive <= 1'b1;
    end
  end

  assign cyc_cnt = r_cnt;
  assign alive   = r_alive;

endmodule

// File: tb/tb_clk_buffer.sv
// Self-checking bench for clk_buffer (CNT_W = 4 to exercise the wrap).
// Works in both the default build and with CLK_BUFFER_GATE_EN defined.
module tb_clk_buffer;

  localparam int TB_W = 4;
  localparam int MOD  = 1 << TB_W;

  typedef struct packed {
    logic [TB_W-1:0] cnt;
    logic            alive;
  } exp_t;

  logic            mclk = 1'b0;
  logic            rst_n = 1'b0;
  logic            gate_en = 1'b1;
  logic            bclk;
  logic [TB_W-1:0] cyc_cnt;
  logic            alive;

  logic            rst_z = 1'bz;
  logic            bclk_z;
  logic [TB_W-1:0] cyc_cnt_z;
  logic            alive_z;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  // reference model state
  int   edges    = 0;
  logic exp_pass = 1'b1;

  time  t_mrise = 0;
  time  t_brise = 0;
  int   n_mrise = 0;
  int   n_brise = 0;

  clk_buffer #(.CNT_W(TB_W)) dut (
    .mclk    (mclk),
    .bclk    (bclk),
    .rst_n   (rst_n),
    .cyc_cnt (cyc_cnt),
    .alive   (alive)
`ifdef CLK_BUFFER_GATE_EN
    ,
    .gate_en (gate_en)
`endif
  );

  // Reset left floating: the clock must still pass.
  clk_buffer #(.CNT_W(TB_W)) u_z (
    .mclk    (mclk),
    .bclk    (bclk_z),
    .rst_n   (rst_z),
    .cyc_cnt (cyc_cnt_z),
    .alive   (alive_z)
`ifdef CLK_BUFFER_GATE_EN
    ,
    .gate_en (1'b1)
`endif
  );

  always #5 mclk = ~mclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  always @(posedge mclk) begin t_mrise = $time; n_mrise++; end
  always @(posedge bclk) begin t_brise = $time; n_brise++; end

  // Monitor: the DUT presents new status after every mclk rising edge.
  always @(posedge mclk) begin
    exp_t e;
    #1;
    check("sb_depth", sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("cyc_cnt", 32'(cyc_cnt), 32'(e.cnt));
      check("alive", 32'(alive), 32'(e.alive));
    end
    check("bclk_hi", 32'(bclk), 32'(exp_pass));
    check("bclk_z_hi", 32'(bclk_z), 32'(mclk));
    if (exp_pass) check("edge_align", 32'(t_brise), 32'(t_mrise));
    #3;
    check("bclk_hi_late", 32'(bclk), 32'(exp_pass));
  end

  always @(negedge mclk) begin
    #1;
    check("bclk_lo", 32'(bclk), 32'(mclk));
    check("bclk_z_lo", 32'(bclk_z), 32'(mclk));
  end

  task automatic push_exp();
    exp_t e;
    e.cnt   = TB_W'(edges % MOD);
    e.alive = (edges != 0);
    sb.push_back(e);
  endtask

  // One mclk period: drive rst_n on the falling edge, predict the next rise.
  task automatic cycle(input logic rst_val);
    @(negedge mclk);
    rst_n = rst_val;
    exp_pass = rst_val ? gate_en : 1'b1;
    if (!rst_val) edges = 0;
    else          edges++;
    push_exp();
  endtask

  task automatic async_reset_check();
    @(negedge mclk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_cnt", 32'(cyc_cnt), 0);
    check("async_alive", 32'(alive), 0);
    exp_pass = 1'b1;
    edges = 0;
    push_exp();
  endtask

  // rst_n falls in the same timestep as an mclk rising edge.
  task automatic simult_reset();
    @(negedge mclk);
    exp_pass = 1'b1;
    edges = 0;
    push_exp();
    @(posedge mclk);
    rst_n = 1'b0;
  endtask

  // Phase/period of the first two rising edges.
  initial begin
    time t1, t2, t3, t4;
    fork
      begin @(posedge mclk); t1 = $time; @(posedge mclk); t2 = $time; end
      begin @(posedge bclk); t3 = $time; @(posedge bclk); t4 = $time; end
    join
    check("t1_eq_t3", 32'(t1), 32'(t3));
    check("t2_eq_t4", 32'(t2), 32'(t4));
    check("mclk_period", 32'(t2 - t1), 10);
    check("bclk_period", 32'(t4 - t3), 10);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0, b0;
    logic [TB_W-1:0] c0;

    push_exp();                       // first rise at t=5, reset asserted
    repeat (2) cycle(1'b0);           // three cycles of reset
    repeat (20) cycle(1'b1);          // counts 1..15, wraps to 0, then 1..4

    repeat (2) cycle(1'b0);
    repeat (7) cycle(1'b1);           // cyc_cnt = 7
    async_reset_check();
    repeat (2) cycle(1'b0);
    repeat (5) cycle(1'b1);

    simult_reset();
    cycle(1'b0);
    repeat (3) cycle(1'b1);

`ifdef CLK_BUFFER_GATE_EN
    @(posedge mclk);
    #2;
    gate_en = 1'b0;
    m0 = n_mrise; b0 = n_brise; c0 = cyc_cnt;
    repeat (4) cycle(1'b1);
    @(posedge mclk);
    #2;
    check("gate_mrise", n_mrise - m0, 4);
    check("gate_brise", n_brise - b0, 0);
    check("gate_cnt", 32'(TB_W'(cyc_cnt - c0)), 4);
    gate_en = 1'b1;
    repeat (4) cycle(1'b1);
`else
    m0 = n_mrise; b0 = n_brise; c0 = cyc_cnt;
    repeat (4) cycle(1'b1);
    check("ungated_rises", n_brise - b0, n_mrise - m0);
`endif

    for (int i = 0; i < 12; i++) begin
      int rl, nl;
      rl = $urandom_range(1, 3);
      nl = $urandom_range(1, 40);
      repeat (rl) cycle(1'b0);
      repeat (nl) cycle(1'b1);
    end

    @(posedge mclk);
    #3;
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
